// File: rtl/inv_dir_sched_pkg.sv
// Shared types for the inverse-direction scheduler: the tagged direction vector and one ROB entry.
// Component/tag widths come from the WIDTH, Q_BITS and TAG_SIZE macros when the build supplies them.
`ifndef WIDTH
`define WIDTH 16
`endif
`ifndef Q_BITS
`define Q_BITS 8
`endif
`ifndef TAG_SIZE
`define TAG_SIZE 8
`endif

package inv_dir_sched_pkg;

    localparam int DIR_WIDTH    = `WIDTH;
    localparam int DIR_Q_BITS   = `Q_BITS;
    localparam int DIR_TAG_SIZE = `TAG_SIZE;

    typedef struct packed {
        logic [DIR_TAG_SIZE-1:0]    tag;
        logic signed [DIR_WIDTH-1:0] x;
        logic signed [DIR_WIDTH-1:0] y;
        logic signed [DIR_WIDTH-1:0] z;
    } tagged_direction_t;

    typedef struct packed {
        logic              done;
        tagged_direction_t data;
    } rob_entry_t;

endpackage

// File: rtl/inv_dir_sched_if.sv
// Valid/ready stream carrying one tagged direction; used for both the input and the in-order output.
interface inv_dir_sched_if;
    import inv_dir_sched_pkg::*;

    logic              valid;
    logic              ready;
    tagged_direction_t dir;

    modport master (output valid, output dir, input ready);
    modport slave  (input valid, input dir, output ready);
endinterface

// File: rtl/inv_dir_sched_rr_lane_pick.sv
// Round-robin picker: first requesting lane at or after ptr, wrapping modulo LANES.
module rr_lane_pick #(
    parameter int LANES = 16
) (
    input  logic [LANES-1:0]         req,
    input  logic [$clog2(LANES)-1:0] ptr,
    output logic [LANES-1:0]         grant,
    output logic [$clog2(LANES)-1:0] grant_idx,
    output logic                     any
);
    localparam int LW = $clog2(LANES);

    logic [LW-1:0] idx_s;
    logic          hit_s;

    // Scan lanes starting at ptr; the first request seen wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx_s     = '0;
        hit_s     = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            idx_s        = LW'((int'(ptr) + i) % LANES);
            hit_s        = !any && req[idx_s];
            grant[idx_s] = hit_s;
            grant_idx    = hit_s ? idx_s : grant_idx;
            any          = any | hit_s;
        end
    end
endmodule

// File: rtl/inv_dir_sched.sv
// Issues directions to external divider lanes round-robin and returns results in acceptance order via a ROB.
// Optional INV_DIR_PERF_EN adds saturating accept/stall counters; otherwise those outputs are tied to 0.
`ifndef WIDTH
`define WIDTH 16
`endif
`ifndef Q_BITS
`define Q_BITS 8
`endif
`ifndef TAG_SIZE
`define TAG_SIZE 8
`endif

module inv_dir_sched
    import inv_dir_sched_pkg::*;
#(
    parameter int WIDTH     = `WIDTH,
    parameter int Q_BITS    = `Q_BITS,
    parameter int TAG_SIZE  = `TAG_SIZE,
    parameter int LANES     = 16,
    parameter int ROB_DEPTH = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    inv_dir_sched_if.slave                s,
    output logic [LANES-1:0]              lane_start,
    output tagged_direction_t             lane_dir,
    input  logic [LANES-1:0]              lane_ready,
    input  logic [LANES-1:0]              lane_valid,
    input  tagged_direction_t [LANES-1:0] lane_result,
    inv_dir_sched_if.master               m,
    output logic [$clog2(ROB_DEPTH):0]    inflight,
    output logic                          err_spurious,
    output logic [31:0]                   perf_accepted,
    output logic [31:0]                   perf_stall
);
    localparam int AW = $clog2(ROB_DEPTH);
    localparam int LW = $clog2(LANES);
    localparam logic [AW:0] ROB_FULL = (AW+1)'(ROB_DEPTH);
    localparam logic [AW:0] CNT_ONE  = {{AW{1'b0}}, 1'b1};

    // Struct widths are fixed by the package, so the parameters must agree with it.
    if (WIDTH != DIR_WIDTH || Q_BITS != DIR_Q_BITS || TAG_SIZE != DIR_TAG_SIZE || Q_BITS >= WIDTH ||
        LANES < 2 || LANES > 32 || ROB_DEPTH < LANES || (ROB_DEPTH & (ROB_DEPTH - 1)) != 0) begin : g_bad_params
        $error("inv_dir_sched: unsupported parameter combination");
    end

    logic [LANES-1:0] busy_r;
    logic [AW-1:0]    lane_seq_r [LANES];
    rob_entry_t       rob_r [ROB_DEPTH];
    logic [AW-1:0]    head_r;
    logic [AW-1:0]    tail_r;
    logic [LW-1:0]    rr_ptr_r;
    logic [AW:0]      inflight_r;
    logic             err_r;

    logic [LANES-1:0] eligible_s;
    logic [LANES-1:0] grant_s;
    logic [LANES-1:0] complete_s;
    logic [LANES-1:0] spurious_s;
    logic [LW-1:0]    grant_idx_s;
    logic [LW-1:0]    rr_ptr_next_s;
    logic             any_eligible_s;
    logic             s_ready_s;
    logic             accept_s;
    logic             m_valid_s;
    logic             drain_s;

    rr_lane_pick #(.LANES(LANES)) u_pick (
        .req       (eligible_s),
        .ptr       (rr_ptr_r),
        .grant     (grant_s),
        .grant_idx (grant_idx_s),
        .any       (any_eligible_s)
    );

    // Handshake decode; reset gating keeps lane_start quiet while reset is held.
    always_comb begin
        eligible_s = lane_ready & ~busy_r;
        complete_s = lane_valid & busy_r;
        spurious_s = lane_valid & ~busy_r;
        s_ready_s  = reset && any_eligible_s && (inflight_r < ROB_FULL);
        accept_s   = s.valid && s_ready_s;
        m_valid_s  = rob_r[head_r].done;
        drain_s    = m_valid_s && m.ready;
        if (accept_s) begin
            lane_start = grant_s;
        end else begin
            lane_start = '0;
        end
        if (grant_idx_s == LW'(LANES - 1)) begin
            rr_ptr_next_s = '0;
        end else begin
            rr_ptr_next_s = grant_idx_s + LW'(1);
        end
    end

    assign s.ready      = s_ready_s;
    assign lane_dir     = s.dir;
    assign m.valid      = m_valid_s;
    assign m.dir        = rob_r[head_r].data;
    assign inflight     = inflight_r;
    assign err_spurious = err_r;

    // ROB pointers, round-robin pointer, occupancy and sticky spurious-result flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_r     <= '0;
            tail_r     <= '0;
            rr_ptr_r   <= '0;
            inflight_r <= '0;
            err_r      <= 1'b0;
        end else begin
            if (accept_s) begin
                tail_r   <= tail_r + AW'(1);
                rr_ptr_r <= rr_ptr_next_s;
            end
            if (drain_s) begin
                head_r <= head_r + AW'(1);
            end
            case ({accept_s, drain_s})
                2'b10:   inflight_r <= inflight_r + CNT_ONE;
                2'b01:   inflight_r <= inflight_r - CNT_ONE;
                default: inflight_r <= inflight_r;
            endcase
            if (|spurious_s) begin
                err_r <= 1'b1;
            end
        end
    end

    // Per-lane busy flag and the ROB slot each busy lane will write back to.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_r <= '0;
            for (int j = 0; j < LANES; j++) begin
                lane_seq_r[j] <= '0;
            end
        end else begin
            for (int j = 0; j < LANES; j++) begin
                if (complete_s[j]) begin
                    busy_r[j] <= 1'b0;
                end
            end
            if (accept_s) begin
                busy_r[grant_idx_s]     <= 1'b1;
                lane_seq_r[grant_idx_s] <= tail_r;
            end
        end
    end

    // ROB storage: every completing lane writes its own slot; the head slot frees on drain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                rob_r[i] <= '0;
            end
        end else begin
            if (drain_s) begin
                rob_r[head_r].done <= 1'b0;
            end
            for (int j = 0; j < LANES; j++) begin
                if (complete_s[j]) begin
                    rob_r[lane_seq_r[j]].data <= lane_result[j];
                    rob_r[lane_seq_r[j]].done <= 1'b1;
                end
            end
        end
    end

`ifdef INV_DIR_PERF_EN
    logic [31:0] perf_acc_r;
    logic [31:0] perf_stall_r;
    logic        stall_s;

    assign stall_s = s.valid && !s_ready_s;

    // Saturating accept and input-stall counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_acc_r   <= 32'h0000_0000;
            perf_stall_r <= 32'h0000_0000;
        end else begin
            if (accept_s && perf_acc_r != 32'hFFFF_FFFF) begin
                perf_acc_r <= perf_acc_r + 32'h0000_0001;
            end
            if (stall_s && perf_stall_r != 32'hFFFF_FFFF) begin
                perf_stall_r <= perf_stall_r + 32'h0000_0001;
            end
        end
    end

    assign perf_accepted = perf_acc_r;
    assign perf_stall    = perf_stall_r;
`else
    assign perf_accepted = 32'h0000_0000;
    assign perf_stall    = 32'h0000_0000;
`endif
endmodule

// File: doc/inv_dir_sched.md
INV_DIR_SCHED -- requirements
Module: inv_dir_sched

Interface
REQ-001 SHALL have parameter WIDTH, default `WIDTH, fixed-point component width.
REQ-002 SHALL have parameter Q_BITS, default `Q_BITS, fractional bits.
REQ-003 SHALL have parameter TAG_SIZE, default `TAG_SIZE, tag width carried in TaggedDirection.
REQ-004 SHALL have parameter LANES, default 16, number of external divider lanes (2..32).
REQ-005 SHALL have parameter ROB_DEPTH, default 32, reorder entries, power of two, >= LANES.
REQ-006 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-008 SHALL have ports s_valid in 1, s_ready out 1, s_dir in TaggedDirection: input direction stream.
REQ-009 SHALL have ports lane_start out LANES, lane_dir out TaggedDirection: one-hot issue plus broadcast operand.
REQ-010 SHALL have ports lane_ready in LANES, lane_valid in LANES, lane_result in LANES x TaggedDirection: per-lane idle, done strobe and result.
REQ-011 SHALL have ports m_valid out 1, m_ready in 1, m_dir out TaggedDirection: in-order inverted output.
REQ-012 SHALL have ports inflight out clog2(ROB_DEPTH)+1, err_spurious out 1, perf_accepted out 32, perf_stall out 32.

Function
REQ-013 s_ready SHALL be 1 iff at least one lane is eligible (lane_ready high, not busy) and inflight < ROB_DEPTH.
REQ-014 On s_valid&s_ready, lane_start SHALL assert the first eligible lane at or after the round-robin pointer in the same cycle (combinational), lane_dir = s_dir; pointer SHALL advance to that lane+1 mod LANES.
REQ-015 Each accept SHALL allocate ROB entry tail, record tail in lane_seq[lane], set lane busy, increment tail mod ROB_DEPTH.
REQ-016 lane_valid[j] with lane j busy SHALL write lane_result[j] into ROB[lane_seq[j]], set its done bit, clear busy; up to LANES writes per cycle SHALL be supported.
REQ-017 lane_valid[j] with lane j not busy SHALL be ignored and SHALL set err_spurious (sticky until reset).
REQ-018 m_valid SHALL equal done bit of ROB[head]; m_dir SHALL be ROB[head] data; m_valid&m_ready SHALL clear the done bit and advance head mod ROB_DEPTH.
REQ-019 m_dir and m_valid SHALL be stable while m_valid&~m_ready (no retraction).
REQ-020 inflight SHALL equal accepts minus drains; simultaneous accept and drain SHALL leave it unchanged.
REQ-021 Minimum latency accept->m_valid SHALL be divider latency +1 cycle (ROB write registered).
REQ-022 Output order SHALL equal acceptance order regardless of lane completion order; tags pass through unaltered.
REQ-023 Full (inflight==ROB_DEPTH) SHALL deassert s_ready even with idle lanes; drain in the same cycle SHALL NOT re-enable s_ready until the next cycle.

Reset
REQ-024 While reset low: head, tail, pointer, inflight, busy, done bits, err_spurious and counters SHALL be 0; m_valid and lane_start SHALL be 0.
REQ-025 Reset mid-operation SHALL discard all in-flight entries; lane results arriving after release for pre-reset issues SHALL be treated per REQ-017.

Configuration
REQ-026 With INV_DIR_PERF_EN defined, perf_accepted SHALL count accepts and perf_stall SHALL count cycles with s_valid&~s_ready, both saturating at 2^32-1.
REQ-027 Without INV_DIR_PERF_EN, perf_accepted and perf_stall SHALL be constant 0 and no counter flops SHALL be synthesised.

Structure
REQ-028 TaggedDirection, WIDTH/Q_BITS/TAG_SIZE defaults and a ROB entry typedef SHALL live in the shared Types package.
REQ-029 The round-robin eligible-lane picker SHALL be one sub-module, rr_lane_pick, parameterised by LANES.

Verification
REQ-030 Single input tag 5, lane 0 completes after 10 cycles -> m_valid with tag 5 at cycle 11, inflight returns to 0.
REQ-031 Tags 0..3 issued to lanes 0..3, lanes complete in order 3,1,0,2 -> output tags 0,1,2,3 in order.
REQ-032 ROB_DEPTH=4, LANES=4, m_ready=0, 5 inputs offered -> 4 accepted, s_ready=0, perf_stall increments per stalled cycle (PERF_EN).
REQ-033 m_ready toggled 1/0 each cycle during 8-entry drain -> m_dir stable while stalled, 8 outputs, no loss or duplicate.
REQ-034 lane_valid[2] pulsed with lane 2 idle -> no output, err_spurious=1 until reset.
REQ-035 Reset asserted with 3 entries in flight -> m_valid=0, inflight=0 immediately; after release fresh tag 9 round-trips correctly.
